// File: rtl/assoc_line_cache.sv
// 2-way set-associative line store with 1-bit LRU per set, victim reporting on miss
// and an independent registered snoop/invalidate port.
module assoc_line_cache #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned LINE_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LINE_W-1:0]         wr_data,
    input  logic                      wdirty,
    input  logic                      we,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         snoop_addr,
    input  logic                      snoop_req,
    input  logic                      snoop_inv,
    output logic                      rd_vld,
    output logic                      hit,
    output logic                      dirty,
    output logic [LINE_W-1:0]         rd_data,
    output logic [ADDR_W-INDEX_W-1:0] tag_out,
    output logic                      hit_way,
    output logic                      snoop_vld,
    output logic                      snoop_found,
    output logic                      snoop_dirty
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned SETS  = 2 ** INDEX_W;

    logic [1:0]        valid_q [SETS];
    logic [1:0]        dirty_q [SETS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q   [SETS][2];
    logic [LINE_W-1:0] data_q  [SETS][2];

    logic [INDEX_W-1:0] idx, sidx;
    logic [TAG_W-1:0]   ctag, stag;
    logic [1:0]         cmatch, smatch;
    logic               chit, cway, sfound, sway, sdirty_c;

    always_comb begin
        idx       = addr[INDEX_W-1:0];
        ctag      = addr[ADDR_W-1:INDEX_W];
        sidx      = snoop_addr[INDEX_W-1:0];
        stag      = snoop_addr[ADDR_W-1:INDEX_W];
        cmatch[0] = valid_q[idx][0] && (tag_q[idx][0] == ctag);
        cmatch[1] = valid_q[idx][1] && (tag_q[idx][1] == ctag);
        smatch[0] = valid_q[sidx][0] && (tag_q[sidx][0] == stag);
        smatch[1] = valid_q[sidx][1] && (tag_q[sidx][1] == stag);
        chit      = |cmatch;
        // One selector serves as hit way, miss victim and write target; way 0 wins ties.
        if (cmatch[0]) begin
            cway = 1'b0;
        end else if (cmatch[1]) begin
            cway = 1'b1;
        end else begin
            cway = lru_q[idx];
        end
        sfound   = |smatch;
        sway     = ~smatch[0];
        sdirty_c = dirty_q[sidx][sway];
    end

    // Invalidate is applied before the write so a same-edge fill to that way survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SETS); i++) begin
                valid_q[i] <= '0;
                dirty_q[i] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (snoop_req && snoop_inv && sfound) begin
                valid_q[sidx][sway] <= 1'b0;
            end
            if (we) begin
                valid_q[idx][cway] <= 1'b1;
                dirty_q[idx][cway] <= wdirty;
                lru_q[idx]         <= ~cway;
            end else if (re && chit) begin
                lru_q[idx] <= ~cway;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx][cway]  <= ctag;
            data_q[idx][cway] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld      <= 1'b0;
            hit         <= 1'b0;
            dirty       <= 1'b0;
            rd_data     <= '0;
            tag_out     <= '0;
            hit_way     <= 1'b0;
            snoop_vld   <= 1'b0;
            snoop_found <= 1'b0;
            snoop_dirty <= 1'b0;
        end else begin
            rd_vld      <= re;
            hit         <= re & chit;
            if (re) begin
                rd_data <= data_q[idx][cway];
                tag_out <= tag_q[idx][cway];
                hit_way <= cway;
                dirty   <= valid_q[idx][cway] & dirty_q[idx][cway];
            end
            snoop_vld   <= snoop_req;
            snoop_found <= snoop_req & sfound;
            snoop_dirty <= snoop_req & sfound & sdirty_c;
        end
    end

endmodule
